// File: rtl/score_display.sv
// Score keeper and multiplexed 4-digit seven-segment driver for the game.
// The optional high-score tracking is built only when SCORE_DISPLAY_HI_SCORE_EN is defined.
module score_display (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        game_over,
    input  logic        fast_mode,
    input  logic        score_tick,
    input  logic        fast_tick,
    input  logic        dp_tick,
    input  logic        blink_tick,
    output logic [1:0]  state,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int DIGITS    = 4;
    localparam int SCORE_MAX = 9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] r;
        int          v;
        r = 16'h0000;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 32'sd10);
            v           = v / 32'sd10;
        end
        return r;
    endfunction

    localparam logic [15:0] MAX_BCD = to_bcd(SCORE_MAX);

    // Ripple BCD increment; the saturated value holds.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == MAX_BCD) begin
            r = v;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    r[4*i +: 4] = v[4*i +: 4];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_map(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] score_r, score_s;
`ifdef SCORE_DISPLAY_HI_SCORE_EN
    logic [15:0] hi_r, hi_s;
`endif
    logic [1:0]  idx_r, idx_s;
    logic [1:0]  show_r, show_s;
    logic        lit_r, lit_s;
    logic        blank_r, blank_s;
    logic [3:0]  an_r, an_s;
    logic [6:0]  seg_r, seg_s;
    logic        tick_s;
    logic [15:0] value_s;
    logic [3:0]  nibble_s;

    // Game phase sequencing and score / high-score update.
    always_comb begin
        tick_s  = fast_mode ? fast_tick : score_tick;
        state_s = state_r;
        score_s = score_r;
        blank_s = blank_r;
`ifdef SCORE_DISPLAY_HI_SCORE_EN
        hi_s    = hi_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    score_s = 16'h0000;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // game_over has priority over a coincident tick
                if (game_over) begin
                    state_s = ST_OVER;
`ifdef SCORE_DISPLAY_HI_SCORE_EN
                    if (score_r > hi_r) begin
                        hi_s = score_r;
                    end else begin
                        hi_s = hi_r;
                    end
`endif
                end else if (tick_s) begin
                    score_s = bcd_inc(score_r);
                end else begin
                    score_s = score_r;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_s = ST_RUN;
                    score_s = 16'h0000;
                    blank_s = 1'b0;
                end else if (blink_tick) begin
                    blank_s = ~blank_r;
                end else begin
                    blank_s = blank_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (state_s != ST_OVER) begin
            blank_s = 1'b0;
        end else begin
            blank_s = blank_s;
        end
    end

    // Digit scan and next display pattern, computed from post-edge state.
    always_comb begin
        if (dp_tick) begin
            idx_s  = idx_r + 2'd1;
            show_s = idx_r;
        end else begin
            idx_s  = idx_r;
            show_s = show_r;
        end
        lit_s = lit_r | dp_tick;
`ifdef SCORE_DISPLAY_HI_SCORE_EN
        value_s = (state_s == ST_IDLE) ? hi_s : score_s;
`else
        value_s = score_s;
`endif
        nibble_s = value_s[{show_s, 2'b00} +: 4];
        if (blank_s || !lit_s) begin
            an_s  = 4'b1111;
            seg_s = 7'b1111111;
        end else begin
            an_s  = ~(4'b0001 << show_s);
            seg_s = seg_map(nibble_s);
        end
    end

    // State, score and display registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            score_r <= 16'h0000;
`ifdef SCORE_DISPLAY_HI_SCORE_EN
            hi_r    <= 16'h0000;
`endif
            idx_r   <= 2'd0;
            show_r  <= 2'd0;
            lit_r   <= 1'b0;
            blank_r <= 1'b0;
            an_r    <= 4'b1111;
            seg_r   <= 7'b1111111;
        end else begin
            state_r <= state_s;
            score_r <= score_s;
`ifdef SCORE_DISPLAY_HI_SCORE_EN
            hi_r    <= hi_s;
`endif
            idx_r   <= idx_s;
            show_r  <= show_s;
            lit_r   <= lit_s;
            blank_r <= blank_s;
            an_r    <= an_s;
            seg_r   <= seg_s;
        end
    end

    assign state     = state_r;
    assign score_bcd = score_r;
`ifdef SCORE_DISPLAY_HI_SCORE_EN
    assign hi_bcd    = hi_r;
`else
    assign hi_bcd    = 16'h0000;
`endif
    assign an        = an_r;
    assign seg       = seg_r;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display; hi-score expectations follow
// whether SCORE_DISPLAY_HI_SCORE_EN is defined.
module tb_score_display;

    logic        clk = 1'b0;
    logic        rst, start, game_over, fast_mode;
    logic        score_tick, fast_tick, dp_tick, blink_tick;
    logic [1:0]  state;
    logic [15:0] score_bcd, hi_bcd;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SCORE_DISPLAY_HI_SCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] OFF = 7'b1111111;

    score_display dut (
        .clk(clk), .rst(rst), .start(start), .game_over(game_over),
        .fast_mode(fast_mode), .score_tick(score_tick), .fast_tick(fast_tick),
        .dp_tick(dp_tick), .blink_tick(blink_tick), .state(state),
        .score_bcd(score_bcd), .hi_bcd(hi_bcd), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
        chk({tag, ".an"}, {12'h000, an}, {12'h000, e_an});
        chk({tag, ".seg"}, {9'h000, seg}, {9'h000, e_seg});
    endtask

    task automatic pulse_dp();    dp_tick = 1'b1;    step(); dp_tick = 1'b0;    endtask
    task automatic pulse_start(); start = 1'b1;      step(); start = 1'b0;      endtask
    task automatic pulse_over();   game_over = 1'b1; step(); game_over = 1'b0;  endtask
    task automatic pulse_blink(); blink_tick = 1'b1; step(); blink_tick = 1'b0; endtask

    task automatic ticks(input int n, input bit use_fast);
        for (int i = 0; i < n; i++) begin
            if (use_fast) fast_tick = 1'b1; else score_tick = 1'b1;
            step();
            fast_tick  = 1'b0;
            score_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; game_over = 1'b0; fast_mode = 1'b0;
        score_tick = 1'b0; fast_tick = 1'b0; dp_tick = 1'b0; blink_tick = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst.state", {14'h0, state}, 16'h0000);
        chk("rst.score", score_bcd, 16'h0000);
        chk("rst.hi", hi_bcd, 16'h0000);
        chk_disp("rst", 4'b1111, OFF);

        // scan in IDLE: shows zero on every digit
        pulse_dp(); chk_disp("scan0", 4'b1110, S0);
        pulse_dp(); chk_disp("scan1", 4'b1101, S0);
        pulse_dp(); chk_disp("scan2", 4'b1011, S0);
        pulse_dp(); chk_disp("scan3", 4'b0111, S0);

        pulse_start();
        chk("run.state", {14'h0, state}, 16'h0001);
        chk("run.score0", score_bcd, 16'h0000);
        ticks(1, 1'b0);  chk("tick1", score_bcd, 16'h0001);
        ticks(1, 1'b1);  chk("fast_ignored1", score_bcd, 16'h0001);
        ticks(11, 1'b0); chk("tick12", score_bcd, 16'h0012);
        ticks(3, 1'b1);  chk("fast_ignored2", score_bcd, 16'h0012);
        pulse_start();
        chk("start_in_run.state", {14'h0, state}, 16'h0001);
        chk("start_in_run.score", score_bcd, 16'h0012);

        // show index 3 is live; blink outside OVER has no effect
        chk_disp("run.d3", 4'b0111, S0);
        pulse_blink(); chk_disp("run.blink", 4'b0111, S0);
        pulse_dp(); chk_disp("run.d0", 4'b1110, S2);
        pulse_dp(); chk_disp("run.d1", 4'b1101, S1);

        pulse_over();
        chk("over1.state", {14'h0, state}, 16'h0002);
        chk("over1.score", score_bcd, 16'h0012);
        chk("over1.hi", hi_bcd, HI_EN ? 16'h0012 : 16'h0000);
        pulse_over();
        chk("over_ignored", {14'h0, state}, 16'h0002);

        pulse_start();
        chk("run2.score0", score_bcd, 16'h0000);
        ticks(99, 1'b0); chk("tick99", score_bcd, 16'h0099);
        ticks(1, 1'b0);  chk("carry100", score_bcd, 16'h0100);
        ticks(23, 1'b0); chk("tick123", score_bcd, 16'h0123);
        game_over = 1'b1; score_tick = 1'b1; step(); game_over = 1'b0; score_tick = 1'b0;
        chk("over2.state", {14'h0, state}, 16'h0002);
        chk("over2.score", score_bcd, 16'h0123);
        chk("over2.hi", hi_bcd, HI_EN ? 16'h0123 : 16'h0000);

        pulse_start();
        ticks(50, 1'b0); chk("tick50", score_bcd, 16'h0050);
        pulse_over();
        chk("over3.state", {14'h0, state}, 16'h0002);
        chk("over3.hi", hi_bcd, HI_EN ? 16'h0123 : 16'h0000);

        // blink in OVER over score 0050
        chk_disp("over.d1", 4'b1101, S5);
        pulse_dp();    chk_disp("over.d2", 4'b1011, S0);
        pulse_blink(); chk_disp("blank1", 4'b1111, OFF);
        pulse_dp();    chk_disp("blank_dp", 4'b1111, OFF);
        pulse_blink(); chk_disp("unblank.d3", 4'b0111, S0);
        pulse_dp();    chk_disp("over.d0", 4'b1110, S0);
        pulse_dp();    chk_disp("over.d1b", 4'b1101, S5);
        pulse_blink(); chk_disp("blank2", 4'b1111, OFF);
        pulse_start();
        chk("restart.state", {14'h0, state}, 16'h0001);
        chk("restart.score", score_bcd, 16'h0000);
        chk_disp("restart", 4'b1101, S0);

        // saturation on fast ticks
        fast_mode = 1'b1;
        ticks(5, 1'b0);    chk("slow_ignored", score_bcd, 16'h0000);
        ticks(9998, 1'b1); chk("tick9998", score_bcd, 16'h9998);
        ticks(3, 1'b1);    chk("saturate", score_bcd, 16'h9999);

        pulse_over();
        chk("over4.hi", hi_bcd, HI_EN ? 16'h9999 : 16'h0000);
        pulse_start();
        ticks(456, 1'b1); chk("tick456", score_bcd, 16'h0456);

        rst = 1'b1; fast_tick = 1'b1; step(); rst = 1'b0; fast_tick = 1'b0;
        chk("rst2.state", {14'h0, state}, 16'h0000);
        chk("rst2.score", score_bcd, 16'h0000);
        chk("rst2.hi", hi_bcd, 16'h0000);
        chk_disp("rst2", 4'b1111, OFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
